// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared parameters and request type for the GPR write-back arbiter slice.
package gpr_wb_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned NWP   = 2;
  localparam int unsigned DEPTH = 4;
  localparam bit          ZERO_DISCARD = 1'b1;

  localparam int unsigned OCCW = $clog2(DEPTH + 1);

  // Requester indices, oldest first in program order.
  localparam int unsigned REQ_MEM_U  = 0;
  localparam int unsigned REQ_MEM_L  = 1;
  localparam int unsigned REQ_EXEC_U = 2;
  localparam int unsigned REQ_EXEC_L = 3;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// Pipeline-request and GPR-write-port bundle for the write-back arbiter.
interface gpr_wb_arbiter_if;
  import gpr_wb_pkg::*;

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0][AW-1:0]   req_addr;
  logic [NREQ-1:0][XLEN-1:0] req_data;
  logic                      stall_o;
  logic [NWP-1:0]            wr_en;
  logic [NWP-1:0][AW-1:0]    wr_addr;
  logic [NWP-1:0][XLEN-1:0]  wr_data;
  logic [2**AW-1:0]          pend_mask;
  logic [OCCW-1:0]           occ;

  modport master (
    output req_valid, req_addr, req_data,
    input  stall_o, wr_en, wr_addr, wr_data, pend_mask, occ
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output stall_o, wr_en, wr_addr, wr_data, pend_mask, occ
  );

endinterface

// File: rtl/gpr_wb_arbiter_pend_fifo.sv
// Pending-write circular buffer: up to NREQ pushes and NWP pops per cycle,
// entries exposed oldest-first with valid marking the occupied prefix.
module wb_pend_fifo
  import gpr_wb_pkg::*;
(
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [$clog2(NWP+1)-1:0]   i_pop_n,
  input  logic [$clog2(NREQ+1)-1:0]  i_push_n,
  input  wb_req_t                    i_push_data [NREQ],
  output wb_req_t                    o_entry     [DEPTH],
  output logic [OCCW-1:0]            o_occ
);

  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t         r_mem [DEPTH];
  logic [PTRW-1:0] r_rd;
  logic [PTRW-1:0] r_wr;
  logic [OCCW-1:0] r_occ;

  function automatic logic [PTRW-1:0] wrap(input logic [PTRW-1:0] base,
                                           input int unsigned ofs);
    int unsigned s;
    s = (32'(base) + ofs) % DEPTH;
    return PTRW'(s);
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_occ <= '0;
    end else begin
      r_rd  <= wrap(r_rd, 32'(i_pop_n));
      r_wr  <= wrap(r_wr, 32'(i_push_n));
      r_occ <= r_occ - OCCW'(i_pop_n) + OCCW'(i_push_n);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (j < 32'(i_push_n)) r_mem[wrap(r_wr, j)] <= i_push_data[j];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      o_entry[k]       = r_mem[wrap(r_rd, k)];
      o_entry[k].valid = (k < 32'(r_occ));
    end
  end

  assign o_occ = r_occ;

endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR write-back arbiter: grants queued then new writes oldest-first onto NWP
// registered write ports, queues overflow, squashes same-address older writes.
module gpr_wb_arbiter
  import gpr_wb_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  gpr_wb_arbiter_if.slave  bus
);

  localparam int unsigned POPW  = $clog2(NWP + 1);
  localparam int unsigned PUSHW = $clog2(NREQ + 1);

  wb_req_t                  w_buf   [DEPTH];
  wb_req_t                  w_req   [NREQ];
  wb_req_t                  w_grant [NWP];
  wb_req_t                  w_push  [NREQ];
  logic [OCCW-1:0]          w_occ;
  logic                     w_stall;
  logic [NREQ-1:0]          w_acc;
  logic [POPW-1:0]          w_pop_n;
  logic [PUSHW-1:0]         w_push_n;
  logic [NWP-1:0]           w_wr_en;
  logic [2**AW-1:0]         w_pend;

  logic [NWP-1:0]           r_wr_en;
  logic [NWP-1:0][AW-1:0]   r_wr_addr;
  logic [NWP-1:0][XLEN-1:0] r_wr_data;

  assign w_stall = (32'(w_occ) > DEPTH - (NREQ - NWP));

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_req[i].valid = 1'b1;
      w_req[i].addr  = bus.req_addr[i];
      w_req[i].data  = bus.req_data[i];
      w_acc[i] = bus.req_valid[i] && !w_stall &&
                 !(ZERO_DISCARD && (bus.req_addr[i] == '0));
    end
  end

  // Candidate list is buffer head then accepted requests; pos is each accepted
  // request's slot in that list, so slots < NWP grant and the rest push.
  always_comb begin
    int unsigned npop;
    int unsigned pos;
    w_grant = '{default: '0};
    w_push  = '{default: '0};
    npop = (32'(w_occ) < NWP) ? 32'(w_occ) : NWP;
    for (int unsigned p = 0; p < NWP; p++) begin
      if (p < npop) w_grant[p] = w_buf[p];
    end
    pos = npop;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_acc[i]) begin
        for (int unsigned p = 0; p < NWP; p++) begin
          if (pos == p) w_grant[p] = w_req[i];
        end
        for (int unsigned j = 0; j < NREQ; j++) begin
          if (pos == NWP + j) w_push[j] = w_req[i];
        end
        pos = pos + 1;
      end
    end
    w_pop_n  = POPW'(npop);
    w_push_n = PUSHW'((pos > NWP) ? pos - NWP : 32'd0);
  end

  always_comb begin
    for (int unsigned p = 0; p < NWP; p++) begin
      w_wr_en[p] = w_grant[p].valid;
      for (int unsigned q = p + 1; q < NWP; q++) begin
        if (w_grant[q].valid && (w_grant[q].addr == w_grant[p].addr)) w_wr_en[p] = 1'b0;
      end
    end
  end

  wb_pend_fifo u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .i_pop_n     (w_pop_n),
    .i_push_n    (w_push_n),
    .i_push_data (w_push),
    .o_entry     (w_buf),
    .o_occ       (w_occ)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_en   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      for (int unsigned p = 0; p < NWP; p++) begin
        r_wr_en[p]   <= w_wr_en[p];
        r_wr_addr[p] <= w_grant[p].addr;
        r_wr_data[p] <= w_grant[p].data;
      end
    end
  end

  always_comb begin
    w_pend = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (w_buf[k].valid) w_pend[w_buf[k].addr] = 1'b1;
    end
    for (int unsigned p = 0; p < NWP; p++) begin
      if (r_wr_en[p]) w_pend[r_wr_addr[p]] = 1'b1;
    end
  end

  assign bus.stall_o   = w_stall;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.pend_mask = w_pend;
  assign bus.occ       = w_occ;

  a_occ_bound: assert property (@(posedge clk) disable iff (!rstn) w_occ <= OCCW'(DEPTH));

  for (genvar p = 0; p < NWP; p++) begin : g_pa
    for (genvar q = p + 1; q < NWP; q++) begin : g_pb
      a_no_dup_port: assert property (@(posedge clk) disable iff (!rstn)
        !(r_wr_en[p] && r_wr_en[q] && (r_wr_addr[p] == r_wr_addr[q])));
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed and random bench for gpr_wb_arbiter against a queue-based reference
// model of the pending writes and a program-order register-file model.
module tb_gpr_wb_arbiter;
  import gpr_wb_pkg::*;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  gpr_wb_arbiter_if bus ();

  gpr_wb_arbiter dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  wr_t             pq [$];
  logic [XLEN-1:0] gold [2**AW];
  logic [XLEN-1:0] seen [2**AW];
  logic [AW-1:0]   clog [$];
  bit              saw_stall;
  int unsigned     total = 0;
  int unsigned     bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
  endtask

  task automatic set_req(input int unsigned i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bus.req_valid[i] = 1'b1;
    bus.req_addr[i]  = a;
    bus.req_data[i]  = d;
  endtask

  task automatic clear_regs();
    for (int r = 0; r < 2**AW; r++) begin
      gold[r] = '0;
      seen[r] = '0;
    end
    clog.delete();
  endtask

  // One clock with the inputs currently driven; model predicts the next outputs.
  task automatic step(output bit acc);
    wr_t             cand [$];
    wr_t             g [NWP];
    wr_t             w;
    logic [NWP-1:0]  m_en;
    logic [2**AW-1:0] pm;
    int unsigned     ng;
    bit              stl;
    stl = (pq.size() > DEPTH - (NREQ - NWP));
    chk("stall_pre", 64'(bus.stall_o), 64'(stl));
    if (bus.stall_o) saw_stall = 1'b1;
    cand = pq;
    if (!stl) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_addr[i] != '0) begin
          w.addr = bus.req_addr[i];
          w.data = bus.req_data[i];
          cand.push_back(w);
          gold[w.addr] = w.data;
        end
      end
    end
    ng = 0;
    while (ng < NWP && cand.size() > 0) begin
      g[ng] = cand.pop_front();
      ng++;
    end
    pq = cand;
    m_en = '0;
    for (int p = 0; p < int'(ng); p++) begin
      m_en[p] = 1'b1;
      for (int q = p + 1; q < int'(ng); q++) begin
        if (g[q].addr == g[p].addr) m_en[p] = 1'b0;
      end
    end
    pm = '0;
    foreach (pq[k]) pm[pq[k].addr] = 1'b1;
    for (int p = 0; p < NWP; p++) if (m_en[p]) pm[g[p].addr] = 1'b1;
    acc = !stl;
    @(posedge clk);
    #1;
    chk("wr_en", 64'(bus.wr_en), 64'(m_en));
    for (int p = 0; p < NWP; p++) begin
      if (m_en[p]) begin
        chk($sformatf("wr_addr%0d", p), 64'(bus.wr_addr[p]), 64'(g[p].addr));
        chk($sformatf("wr_data%0d", p), 64'(bus.wr_data[p]), 64'(g[p].data));
      end
    end
    chk("occ", 64'(bus.occ), 64'(pq.size()));
    chk("occ_bound", 64'(bus.occ <= DEPTH), 64'd1);
    chk("pend_mask", 64'(bus.pend_mask), 64'(pm));
    for (int p = 0; p < NWP; p++) begin
      if (bus.wr_en[p]) begin
        seen[bus.wr_addr[p]] = bus.wr_data[p];
        clog.push_back(bus.wr_addr[p]);
      end
    end
  endtask

  // Upstream behaviour: re-present the same bundle until it is accepted.
  task automatic send();
    bit          acc;
    int unsigned n;
    n = 0;
    do begin
      step(acc);
      n++;
    end while (!acc && n < 32);
    chk("accept_within_bound", 64'(acc), 64'd1);
    idle();
  endtask

  task automatic drain();
    bit          acc;
    int unsigned n;
    idle();
    n = 0;
    while (pq.size() > 0 && n < 16) begin
      step(acc);
      n++;
    end
    chk("drain_empty", 64'(pq.size()), 64'd0);
    step(acc);
  endtask

  task automatic reset_step();
    rstn = 1'b0;
    idle();
    pq.delete();
    @(posedge clk);
    #1;
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
    chk("rst_occ", 64'(bus.occ), 64'd0);
    chk("rst_pend_mask", 64'(bus.pend_mask), 64'd0);
    chk("rst_stall", 64'(bus.stall_o), 64'd0);
    rstn = 1'b1;
  endtask

  initial begin
    bit acc;
    idle();
    saw_stall = 1'b0;
    clear_regs();
    reset_step();

    // Single exec_u request bypasses straight to port 0.
    set_req(REQ_EXEC_U, 5'd7, 32'hDEAD);
    send();
    chk("single_wr_en", 64'(bus.wr_en), 64'b01);
    chk("single_addr", 64'(bus.wr_addr[0]), 64'd7);
    chk("single_data", 64'(bus.wr_data[0]), 64'hDEAD);
    chk("single_occ", 64'(bus.occ), 64'd0);
    drain();

    // Four requests: two granted, two queued and written ahead of new ones.
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 32'(32'h100 + i));
    send();
    chk("four_addr0", 64'(bus.wr_addr[0]), 64'd1);
    chk("four_addr1", 64'(bus.wr_addr[1]), 64'd2);
    chk("four_occ", 64'(bus.occ), 64'd2);
    chk("four_pend3", 64'(bus.pend_mask[3]), 64'd1);
    chk("four_pend4", 64'(bus.pend_mask[4]), 64'd1);
    set_req(REQ_MEM_U, 5'd9, 32'h9);
    set_req(REQ_MEM_L, 5'd10, 32'hA);
    send();
    chk("four_next_addr0", 64'(bus.wr_addr[0]), 64'd3);
    chk("four_next_addr1", 64'(bus.wr_addr[1]), 64'd4);
    drain();

    // Same-address squash: only the younger exec_u write reaches r5.
    set_req(REQ_MEM_U, 5'd5, 32'h1);
    set_req(REQ_EXEC_U, 5'd5, 32'h2);
    send();
    chk("squash_wr_en", 64'(bus.wr_en), 64'b10);
    chk("squash_addr", 64'(bus.wr_addr[1]), 64'd5);
    chk("squash_data", 64'(bus.wr_data[1]), 64'h2);
    drain();

    // Back-pressure: three full bundles, twelve distinct writes in order.
    clear_regs();
    saw_stall = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 5'(c * NREQ + i + 1), 32'(32'hB000 + c * NREQ + i));
      send();
    end
    drain();
    chk("bp_stalled", 64'(saw_stall), 64'd1);
    chk("bp_count", 64'(clog.size()), 64'd12);
    for (int k = 0; k < 12 && k < clog.size(); k++)
      chk($sformatf("bp_order%0d", k), 64'(clog[k]), 64'(k + 1));
    for (int r = 1; r <= 12; r++)
      chk($sformatf("bp_reg%0d", r), 64'(seen[r]), 64'(gold[r]));

    // Zero register write is dropped outright.
    set_req(REQ_EXEC_L, 5'd0, 32'h5555);
    send();
    chk("zero_wr_en", 64'(bus.wr_en), 64'd0);
    chk("zero_pend0", 64'(bus.pend_mask[0]), 64'd0);
    chk("zero_occ", 64'(bus.occ), 64'd0);

    // Reset with three writes queued: none of them may appear afterwards.
    for (int i = 0; i < 3; i++) set_req(i, 5'(i + 1), 32'(32'hC000 + i));
    send();
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 4), 32'(32'hD000 + i));
    send();
    chk("mid_occ", 64'(bus.occ), 64'd3);
    reset_step();
    for (int c = 0; c < 3; c++) begin
      step(acc);
      chk("post_rst_wr_en", 64'(bus.wr_en), 64'd0);
    end

    // Random traffic with collisions, zero-register writes and back-pressure.
    clear_regs();
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 2) != 0)
          set_req(i, 5'($urandom_range(0, 7)), $urandom);
      end
      send();
    end
    drain();
    for (int r = 1; r < 2**AW; r++)
      chk($sformatf("rand_reg%0d", r), 64'(seen[r]), 64'(gold[r]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
